// File: rtl/rs_pkg.sv
// Shared definitions for the Reed-Solomon encode path over GF(2^8).
// Provides the code geometry (N, NPAR, K), the field polynomial, the byte
// type, a GF(2^8) multiplier, the generator polynomial coefficients built
// at elaboration, and the encoder FSM state type.
package rs_pkg;

  localparam int         N         = 200;
  localparam int         NPAR      = 16;
  localparam int         K         = N - NPAR;
  localparam logic [8:0] PRIM_POLY = 9'h11D;

  typedef logic [7:0] byte_t;

  // Generator coefficients; element j multiplies x^j. The monic x^NPAR
  // term is implicit.
  typedef logic [NPAR-1:0][7:0] gen_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_FINISH = 2'd2
  } rs_enc_state_e;

  // Shift-and-reduce multiply mod PRIM_POLY. With one constant operand this
  // collapses to a small XOR network.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      if (sh[7]) sh = {sh[6:0], 1'b0} ^ PRIM_POLY[7:0];
      else       sh = {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  // g(x) = prod_{i=0..NPAR-1} (x + alpha^i), alpha = 2. Each pass multiplies
  // the running product by one root factor; the leading 1 that appears on
  // the final pass is the implicit monic term and is dropped.
  function automatic gen_t rs_gen_build();
    gen_t  g;
    byte_t root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR - 1; j > 0; j--) begin
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      end
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g;
  endfunction

  localparam gen_t RS_GEN = rs_gen_build();

endpackage

// File: rtl/rs_enc_lfsr.sv
// Parity LFSR for the systematic RS encoder. Divides the message stream
// (highest-degree byte first) by the generator polynomial; after the last
// message byte the registers hold the remainder.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr           synchronous clear of all parity registers (wins over step)
//   step          shift in din this cycle
//   din           message byte
//   parity        p[0..NPAR-1], p[j] at [j*8+:8] (p[j] = coefficient of x^j)
module rs_enc_lfsr
  import rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                step,
  input  logic [7:0]          din,
  output logic [NPAR*8-1:0]   parity
);

  logic [NPAR-1:0][7:0] p_q;
  logic [NPAR-1:0][7:0] p_d;
  byte_t                fb;

  assign fb = din ^ p_q[NPAR-1];

  always_comb begin
    p_d = p_q;
    if (clr) begin
      p_d = '0;
    end else if (step) begin
      p_d[0] = gf_mul(fb, RS_GEN[0]);
      for (int j = 1; j < NPAR; j++) begin
        p_d[j] = p_q[j-1] ^ gf_mul(fb, RS_GEN[j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= p_d;
  end

  assign parity = p_q;

endmodule

// File: rtl/rs_encode_wrapper.sv
// Systematic RS(200,184) encoder wrapper. Captures a K-byte message, runs it
// byte-serially through the parity LFSR and presents an N-byte codeword in
// the layout the decode wrapper consumes.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clrn           sync active-low clear, masked while scan_mode=1
//   scan_mode      DFT mode
//   encode_en      start request, taken only while ready=1
//   message        K bytes, byte i at [i*8+:8], byte 0 = highest degree
//   codeword       bytes 0..K-1 message, bytes K..N-1 parity (x^15 first)
//   output_valid   codeword holds a complete result
//   ready          idle, will accept encode_en
//
// state     | meaning
// ST_IDLE   | waiting for encode_en; last result (if any) held on outputs
// ST_ENCODE | feeding captured byte[counter] into the LFSR, one per cycle
// ST_FINISH | loading message + remainder into the codeword register
module rs_encode_wrapper
  import rs_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clrn,
  input  logic               scan_mode,
  input  logic               encode_en,
  input  logic [K*8-1:0]     message,
  output logic [N*8-1:0]     codeword,
  output logic               output_valid,
  output logic               ready
);

  localparam logic [7:0] LAST_IDX = 8'(K - 1);

  rs_enc_state_e         state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [K*8-1:0]        msg_q, msg_d;
  logic [N*8-1:0]        cw_q, cw_d;
  logic                  valid_q, valid_d;

  logic                  clear;
  logic                  lfsr_clr;
  logic                  lfsr_step;
  logic [10:0]           feed_idx;
  byte_t                 feed_byte;
  logic [NPAR*8-1:0]     parity;
  logic [NPAR*8-1:0]     parity_rev;

  assign clear     = ~clrn & ~scan_mode;
  assign feed_idx  = {cnt_q, 3'b000};
  assign feed_byte = msg_q[feed_idx +: 8];

  // Codeword byte K+m carries p[NPAR-1-m]: highest-degree remainder first.
  for (genvar m = 0; m < NPAR; m++) begin : g_par_rev
    assign parity_rev[m*8 +: 8] = parity[(NPAR-1-m)*8 +: 8];
  end

  rs_enc_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (lfsr_clr),
    .step   (lfsr_step),
    .din    (feed_byte),
    .parity (parity)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    msg_d     = msg_q;
    cw_d      = cw_q;
    valid_d   = valid_q;
    lfsr_clr  = 1'b0;
    lfsr_step = 1'b0;
    if (clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      msg_d    = '0;
      cw_d     = '0;
      valid_d  = 1'b0;
      lfsr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (encode_en) begin
            msg_d    = message;
            cnt_d    = '0;
            valid_d  = 1'b0;
            lfsr_clr = 1'b1;
            state_d  = ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          lfsr_step = 1'b1;
          // Counter parks on the last index instead of running past K-1.
          if (cnt_q == LAST_IDX) state_d = ST_FINISH;
          else                   cnt_d   = cnt_q + 8'd1;
        end
        ST_FINISH: begin
          cw_d    = {parity_rev, msg_q};
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
      cw_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      cw_q    <= cw_d;
      valid_q <= valid_d;
    end
  end

  assign codeword     = cw_q;
  assign output_valid = valid_q;
  assign ready        = (state_q == ST_IDLE);

endmodule

// File: doc/rs_encode_wrapper.md
Name: rs_encode_wrapper

Overview:
- Systematic Reed-Solomon encoder over GF(2^8): the transmit-side counterpart of the rs_decode wrapper.
- Captures a K-byte message bus and feeds it byte-serially through a parity LFSR.
- Emits an N-byte codeword bus laid out exactly as the decode wrapper's encoded_data input expects.
- Sits between the key/data source and storage; its output is the decoder's input.

Parameters:
- N, 200, codeword length in bytes.
- NPAR, 16, parity bytes; K = N-NPAR = 184 message bytes (localparam, not overridable).
- PRIM_POLY, 9'h11D, GF(2^8) field polynomial; alpha = 8'h02.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clrn  input  1  synchronous active-low clear; ignored while scan_mode=1.
- scan_mode  input  1  DFT mode; masks clrn.
- encode_en  input  1  start request; accepted only when ready=1.
- message  input  K*8  message; byte i at [i*8+:8]; byte 0 = highest-degree coefficient.
- codeword  output  N*8  bytes 0..K-1 = message; bytes K..N-1 = parity.
- output_valid  output  1  codeword holds a complete result.
- ready  output  1  idle, can accept encode_en.

Behaviour:
- Clock and reset: clk; rst_n asynchronous, active-low.
- rst_n=0 (async), or clrn=0 with scan_mode=0 (sync): state=IDLE, codeword=0, output_valid=0, ready=1, byte counter=0, LFSR=0, message capture register=0. Clear has priority over every other event in that cycle.
- Generator: g(x) = prod_{i=0..NPAR-1} (x - alpha^i), monic. Coefficients g[0..NPAR-1] (g[j] multiplies x^j) are compile-time constants.
- LFSR registers p[0..NPAR-1], 8 bits each. Per ENCODE step with byte d:
  - fb = d ^ p[NPAR-1]
  - p[0] <= gfmul(fb, g[0])
  - p[j] <= p[j-1] ^ gfmul(fb, g[j]) for j = 1..NPAR-1
  - All arithmetic is GF(2^8) mod PRIM_POLY; addition is XOR.
- FSM, states IDLE, ENCODE, FINISH:
  - IDLE: on encode_en=1, at edge E0:
    - capture message into an internal register; later changes on message are ignored
    - LFSR=0, counter=0, ready<=0, output_valid<=0, state<=ENCODE
  - ENCODE: each cycle, feed captured byte[counter] and increment counter. After the byte K-1 step (edge E_K), state<=FINISH.
  - FINISH (edge E_K+1):
    - codeword[0..K-1] <= captured message
    - codeword byte K+m <= p[NPAR-1-m]
    - output_valid<=1, ready<=1, state<=IDLE
- Latency: output_valid rises K+1 = 185 cycles after the accepting edge. Throughput is one codeword per K+2 cycles.
- output_valid and codeword hold until the next accepted encode_en or a reset/clear. output_valid drops on the accepting edge; codeword keeps its old value until FINISH.
- encode_en while ready=0: ignored; no queuing.
- encode_en held high in IDLE after FINISH: a new encode starts on the next cycle.
- Counter width is 8 bits. It never wraps past K-1.
- Illegal state encoding returns to IDLE with ready=1.
- Compatibility: every codeword produced, fed to the decode wrapper, must yield with_error=0 and all-zero error_pos.

Decomposition:
- Package rs_pkg:
  - N, NPAR, K, PRIM_POLY
  - byte_t typedef
  - gf_mul function (shift-and-reduce)
  - function building the RS_GEN[NPAR] coefficient array at elaboration
  - state enum rs_enc_state_e
- Sub-module rs_enc_lfsr:
  - ports clk, rst_n, clr, step, din[7:0], parity[NPAR*8-1:0]
  - holds p[] and the constant multipliers
- Wrapper owns the FSM, counter, capture register and output registers.

Test Plan:
- Reset, then all-zero message, encode_en pulse -> output_valid=1 exactly 185 cycles later, codeword all zero, ready back to 1.
- Message byte K-1 = 8'h01, others 0 -> codeword bytes 0..K-2 = 0, byte K-1 = 01, byte K+m = RS_GEN[NPAR-1-m] for m = 0..15.
- Random messages A and B, plus A^B -> parity(A^B) = parity(A)^parity(B). Each codeword passed to the decode wrapper gives with_error=0 and error_pos=0.
- Pulse encode_en again at cycle 50 of an encode, and change message mid-encode -> result equals the original message's codeword; no second encode starts.
- clrn=0 at cycle 100 with scan_mode=0 -> next cycle ready=1, output_valid=0, codeword=0. Repeat with scan_mode=1 -> encode completes normally.
- Async rst_n low mid-ENCODE -> outputs reset immediately without a clock edge. Re-encode after release -> correct codeword.
